rggen_apb_command_master: RTL and testbench

//  APB initiator: the other end of the register-block APB adapter. Turns a

---
 rtl/rggen_apb_command_master_if.sv | 27 ++
 rtl/rggen_apb_command_master.sv | 128 ++++++++++++
 tb/tb_rggen_apb_command_master.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rggen_apb_command_master_if.sv
// APB3/APB4 bus bundle shared by the command master and the register-block slave.
// The master drives request fields; the slave returns pready/prdata/pslverr.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_apb_command_master.sv
// APB initiator: one command in, one single APB transfer, one response out.
// Zero-wait latency is 3 cycles from accept to rsp_valid; commands stall while a transfer or response is pending.
module rggen_apb_command_master #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  input  logic [2:0]               i_cmd_prot,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_data,
  output logic [1:0]               o_rsp_status,
  rggen_apb_if.master              apb_if
);
  localparam int STRB_W = BUS_WIDTH / 8;
  // A zero timeout still needs a legal 1-bit counter; it is simply never advanced.
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                   state_q,      state_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q,      paddr_d;
  logic                     pwrite_q,     pwrite_d;
  logic [BUS_WIDTH-1:0]     pwdata_q,     pwdata_d;
  logic [STRB_W-1:0]        pstrb_q,      pstrb_d;
  logic [2:0]               pprot_q,      pprot_d;
  logic [BUS_WIDTH-1:0]     rsp_data_q,   rsp_data_d;
  logic [1:0]               rsp_status_q, rsp_status_d;
  logic [CNT_W-1:0]         cnt_q,        cnt_d;
  logic                     expired;

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    pprot_d      = pprot_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          paddr_d  = i_cmd_address;
          pwrite_d = i_cmd_write;
          pwdata_d = i_cmd_data;
          pprot_d  = i_cmd_prot;
          pstrb_d  = i_cmd_write ? i_cmd_strobe : '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready wins over a timeout expiring in the same cycle.
        if (apb_if.pready) begin
          rsp_data_d   = (!pwrite_q && !apb_if.pslverr) ? apb_if.prdata : '0;
          rsp_status_d = {1'b0, apb_if.pslverr};
          cnt_d        = '0;
          state_d      = RESP;
        end else if (expired) begin
          rsp_data_d   = '0;
          rsp_status_d = 2'b10;
          cnt_d        = '0;
          state_d      = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      pprot_q      <= pprot_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      cnt_q        <= cnt_d;
    end
  end

  // Handshake strobes decode straight from state so reset drops them at once.
  assign o_cmd_ready    = (state_q == IDLE);
  assign o_rsp_valid    = (state_q == RESP);
  assign o_rsp_data     = rsp_data_q;
  assign o_rsp_status   = rsp_status_q;
  assign apb_if.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_if.penable = (state_q == ACCESS);
  assign apb_if.paddr   = paddr_q;
  assign apb_if.pwrite  = pwrite_q;
  assign apb_if.pwdata  = pwdata_q;
  assign apb_if.pstrb   = pstrb_q;
  assign apb_if.pprot   = pprot_q;
endmodule

// File: tb/tb_rggen_apb_command_master.sv
// Directed bench for rggen_apb_command_master with a 4-cycle watchdog.
// The bench plays the APB slave by driving pready/prdata/pslverr step by step.
module tb_rggen_apb_command_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_address;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strobe;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  int          n_chk  = 0;
  int          n_fail = 0;

  rggen_apb_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) apb ();

  rggen_apb_command_master #(
    .ADDRESS_WIDTH (16),
    .BUS_WIDTH     (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_write  (cmd_write),
    .i_cmd_address(cmd_address),
    .i_cmd_data   (cmd_data),
    .i_cmd_strobe (cmd_strobe),
    .i_cmd_prot   (cmd_prot),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_status (rsp_status),
    .apb_if       (apb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [2:0] prot);
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_address = addr;
    cmd_data    = data;
    cmd_strobe  = strb;
    cmd_prot    = prot;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_data = '0;
    cmd_strobe = '0; cmd_prot = '0; rsp_ready = 1'b1;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_psel",      32'(apb.psel), 32'd0);
    chk("rst_penable",   32'(apb.penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr",     32'(apb.paddr), 32'd0);
    chk("rst_rsp_stat",  32'(rsp_status), 32'd0);
    tick(); rst = 1'b0;

    // 1: zero-wait write
    cmd(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 3'd2); apb.pready = 1'b1;
    tick(); cmd_valid = 1'b0;
    chk("t1_psel_c1",    32'(apb.psel), 32'd1);
    chk("t1_pen_c1",     32'(apb.penable), 32'd0);
    chk("t1_pwrite",     32'(apb.pwrite), 32'd1);
    chk("t1_paddr",      32'(apb.paddr), 32'h0004);
    chk("t1_pwdata",     apb.pwdata, 32'hDEADBEEF);
    chk("t1_pstrb",      32'(apb.pstrb), 32'hF);
    chk("t1_pprot",      32'(apb.pprot), 32'd2);
    chk("t1_cmd_rdy_c1", 32'(cmd_ready), 32'd0);
    tick();
    chk("t1_pen_c2",     32'(apb.penable), 32'd1);
    chk("t1_psel_c2",    32'(apb.psel), 32'd1);
    tick();
    chk("t1_rsp_vld_c3", 32'(rsp_valid), 32'd1);
    chk("t1_psel_c3",    32'(apb.psel), 32'd0);
    chk("t1_status",     32'(rsp_status), 32'd0);
    chk("t1_data",       rsp_data, 32'd0);
    tick();
    chk("t1_rsp_vld_c4", 32'(rsp_valid), 32'd0);
    chk("t1_cmd_rdy_c4", 32'(cmd_ready), 32'd1);

    // 2: read with 3 wait states; pready on the 4th ACCESS cycle also meets timeout expiry
    cmd(1'b0, 16'h0010, 32'h0, 4'hF, 3'd0); apb.pready = 1'b0; apb.prdata = 32'h12345678;
    tick(); cmd_valid = 1'b0;
    chk("t2_pstrb_rd",   32'(apb.pstrb), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_penable",  32'(apb.penable), 32'd1);
      chk("t2_paddr",    32'(apb.paddr), 32'h0010);
      if (i == 3) apb.pready = 1'b1;
      tick();
    end
    apb.pready = 1'b0;
    chk("t2_rsp_vld",    32'(rsp_valid), 32'd1);
    chk("t2_penable_off",32'(apb.penable), 32'd0);
    chk("t2_data",       rsp_data, 32'h12345678);
    chk("t2_status",     32'(rsp_status), 32'd0);
    tick();

    // 3a: read with pslverr
    cmd(1'b0, 16'h0020, 32'h0, 4'h0, 3'd0); apb.pready = 1'b1; apb.pslverr = 1'b1;
    apb.prdata = 32'hAAAA5555;
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    chk("t3_rd_status",  32'(rsp_status), 32'd1);
    chk("t3_rd_data",    rsp_data, 32'd0);
    tick();
    // 3b: write with pslverr
    cmd(1'b1, 16'h0024, 32'h11112222, 4'h3, 3'd0);
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    chk("t3_wr_rsp_vld", 32'(rsp_valid), 32'd1);
    chk("t3_wr_status",  32'(rsp_status), 32'd1);
    tick();
    apb.pslverr = 1'b0;

    // 4: timeout with pready held low
    cmd(1'b0, 16'h0030, 32'h0, 4'h0, 3'd0); apb.pready = 1'b0; apb.prdata = 32'h5A5A5A5A;
    tick(); cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_penable",  32'(apb.penable), 32'd1);
      tick();
    end
    chk("t4_psel_off",   32'(apb.psel), 32'd0);
    chk("t4_rsp_vld",    32'(rsp_valid), 32'd1);
    chk("t4_status",     32'(rsp_status), 32'd2);
    chk("t4_data",       rsp_data, 32'd0);
    tick();
    chk("t4_cmd_rdy",    32'(cmd_ready), 32'd1);
    cmd(1'b1, 16'h0034, 32'h0000BEEF, 4'h1, 3'd0); apb.pready = 1'b1;
    tick(); cmd_valid = 1'b0;
    chk("t4_next_psel",  32'(apb.psel), 32'd1);
    tick(); tick();
    chk("t4_next_status",32'(rsp_status), 32'd0);
    tick();

    // 5: response backpressure with a following command held valid
    rsp_ready = 1'b0;
    cmd(1'b0, 16'h0040, 32'hFFFFFFFF, 4'hF, 3'd1); apb.pready = 1'b1; apb.prdata = 32'hCAFEF00D;
    tick(); tick(); tick();
    apb.prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rsp_vld",  32'(rsp_valid), 32'd1);
      chk("t5_data",     rsp_data, 32'hCAFEF00D);
      chk("t5_cmd_rdy",  32'(cmd_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t5_rsp_vld_off",32'(rsp_valid), 32'd0);
    chk("t5_cmd_rdy_on", 32'(cmd_ready), 32'd1);
    tick(); cmd_valid = 1'b0;
    chk("t5_psel",       32'(apb.psel), 32'd1);
    chk("t5_pstrb_rd",   32'(apb.pstrb), 32'd0);
    tick(); tick();
    chk("t5_data2",      rsp_data, 32'h0);
    tick();

    // 6: reset during ACCESS, then a fresh read
    cmd(1'b1, 16'h0050, 32'h01020304, 4'hF, 3'd0); apb.pready = 1'b0;
    tick(); cmd_valid = 1'b0;
    tick();
    chk("t6_pen_pre",    32'(apb.penable), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_psel_rst",   32'(apb.psel), 32'd0);
    chk("t6_pen_rst",    32'(apb.penable), 32'd0);
    chk("t6_rspv_rst",   32'(rsp_valid), 32'd0);
    tick(); rst = 1'b0;
    chk("t6_cmd_rdy",    32'(cmd_ready), 32'd1);
    cmd(1'b0, 16'h0060, 32'h0, 4'h0, 3'd0); apb.pready = 1'b1; apb.prdata = 32'h0BADCAFE;
    tick(); cmd_valid = 1'b0;
    chk("t6_psel",       32'(apb.psel), 32'd1);
    tick(); tick();
    chk("t6_rsp_vld",    32'(rsp_valid), 32'd1);
    chk("t6_data",       rsp_data, 32'h0BADCAFE);
    chk("t6_status",     32'(rsp_status), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
